bram_s1_fifo_ctrl: RTL
======================

// Module: bram_s1_fifo_ctrl
// PURPOSE
//  Bit-serial FIFO controller driving one 4096x1 single-port synchronous block RAM (1-cycle read latency).
//  Sits upstream of the RAM: generates ADDR/DI/WE/EN/RST, consumes DO into a 1-bit output register.
//  Arbitrates the single RAM port between writes and reads; valid/ready on both sides.
// PARAMETERS
//  ADDR_W      12    RAM address width; DEPTH = 2**ADDR_W bits of storage
//  AFULL_LVL   4000  almost-full threshold on LEVEL (only with BRAM_FIFO_LEVEL_EN)
// PORTS
//  CLK         in   1       clock, all logic on rising edge
//  RST_N       in   1       asynchronous, active-low reset
//  WR_VALID    in   1       write bit offered
//  WR_DATA     in   1       write bit
//  WR_READY    out  1       write accepted this cycle when WR_VALID&WR_READY
//  RD_VALID    out  1       output register holds a bit
//  RD_DATA     out  1       output bit
//  RD_READY    in   1       consumer pops when RD_VALID&RD_READY
//  RAM_ADDR    out  ADDR_W  RAM address
//  RAM_DI      out  1       RAM write data
//  RAM_WE      out  1       RAM write enable
//  RAM_EN      out  1       RAM enable (1 only on a write or read access)
//  RAM_RST     out  1       RAM output reset; constant 0
//  RAM_DO      in   1       RAM read data, valid one cycle after read access
// BEHAVIOUR
//  Reset (RST_N=0, async): wr_ptr=rd_ptr=0, ram_cnt=0, state=S_IDLE, RD_VALID=0, RD_DATA=0, WR_READY=0,
//   RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0. RAM contents not cleared; stale bits never surfaced.
//  ram_cnt: bits stored in RAM, 0..DEPTH (ADDR_W+1 bits). Pointers ADDR_W bits, wrap DEPTH-1 -> 0.
//  FSM: S_IDLE (no read in flight), S_RD_WAIT (read issued last cycle; RAM_DO captured this cycle).
//  S_RD_WAIT -> S_IDLE unconditionally; RD_DATA<=RAM_DO, RD_VALID<=1 on that edge.
//  rd_slot = state==S_IDLE && ram_cnt!=0 && (!RD_VALID || RD_READY).
//  rd_go   = rd_slot && !RD_VALID      (starved output: read wins the port)
//          | rd_slot && !WR_VALID      (port otherwise idle).
//  WR_READY = (ram_cnt!=DEPTH) && !rd_go; combinational, not dependent on WR_VALID.
//  Write access: RAM_EN=1, RAM_WE=1, RAM_ADDR=wr_ptr, RAM_DI=WR_DATA; wr_ptr++.
//  Read access:  RAM_EN=1, RAM_WE=0, RAM_ADDR=rd_ptr; rd_ptr++, state->S_RD_WAIT.
//  At most one access per cycle; no access -> RAM_EN=0, RAM_ADDR/RAM_DI hold last value.
//  ram_cnt: +1 write only, -1 read only; no simultaneous case exists (single port).
//  Pop with no refill: RD_VALID<=0 unless S_RD_WAIT delivers that cycle.
//  Write latency: bit readable at RD_DATA >=2 cycles after acceptance (write, read, capture).
//  Read throughput: max 1 bit per 2 cycles (one read in flight at a time).
//  Full (ram_cnt==DEPTH): WR_READY=0; drops when pops free a location. Empty: no read issued.
//  Reset mid-operation: in-flight read discarded, output register cleared, FIFO empty.
// CONFIGURATION
//  Macro BRAM_FIFO_LEVEL_EN defined: extra outputs LEVEL [ADDR_W+1:0] = ram_cnt + (state==S_RD_WAIT)
//   + RD_VALID, registered, reset 0; ALMOST_FULL = (LEVEL >= AFULL_LVL), registered, reset 0.
//  Not defined: LEVEL/ALMOST_FULL ports and logic absent; AFULL_LVL unused; core behaviour identical.
// STRUCTURE
//  Shared package bram_fifo_pkg: state encoding S_IDLE=1'b0/S_RD_WAIT=1'b1, DEFAULT_ADDR_W=12,
//   DEFAULT_AFULL_LVL=4000, DEPTH function of ADDR_W.
//  One sub-module: bram_fifo_ptr (wrapping ADDR_W pointer with increment enable, async active-low reset),
//   instantiated twice (wr_ptr, rd_ptr). Arbitration, FSM, output register in top level.
// TESTING
//  1 Reset then write 1,0,1,1 with RD_READY=0 -> RAM_WE pulses at ADDR 0..3; RD_DATA=1 first, RD_VALID held.
//  2 Continue 1 with RD_READY=1 -> pops 1,0,1,1 in order, one per 2 cycles; RD_VALID=0 after last.
//  3 Write 4096 bits, RD_READY=0 -> first bit in output reg; WR_READY=0 when ram_cnt=4096; pop one -> WR_READY=1.
//  4 Wrap: stream 10000 random bits in/out with random valid/ready -> output sequence equals input, no loss.
//  5 RD_VALID=0, ram_cnt>0, WR_VALID=1 same cycle -> read issued, WR_READY=0 that cycle, write next cycle.
//  6 Assert RST_N=0 during S_RD_WAIT -> RD_VALID=0, RAM_EN=0 immediately; after release FIFO empty.
//  7 With BRAM_FIFO_LEVEL_EN, AFULL_LVL=8: write 8 bits, no pops -> LEVEL=8, ALMOST_FULL=1.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared types and defaults for the bit-serial block-RAM FIFO controller.
package bram_fifo_pkg;

    localparam int unsigned DEFAULT_ADDR_W    = 12;
    localparam int unsigned DEFAULT_AFULL_LVL = 4000;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_t;

    // Storage depth in bits for a given RAM address width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/bram_fifo_ptr.sv
// Wrapping RAM address pointer; advances by one when inc is high.
module bram_fifo_ptr #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/bram_s1_fifo_ctrl.sv
// Bit-serial FIFO controller for a single-port 1-bit-wide synchronous block RAM.
// Optional occupancy outputs LEVEL/ALMOST_FULL when BRAM_FIFO_LEVEL_EN is defined.
module bram_s1_fifo_ctrl
    import bram_fifo_pkg::*;
#(
`ifdef BRAM_FIFO_LEVEL_EN
    parameter int unsigned AFULL_LVL = DEFAULT_AFULL_LVL,
`endif
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_VALID,
    input  logic              WR_DATA,
    output logic              WR_READY,
    output logic              RD_VALID,
    output logic              RD_DATA,
    input  logic              RD_READY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_DI,
    output logic              RAM_WE,
    output logic              RAM_EN,
    output logic              RAM_RST,
`ifdef BRAM_FIFO_LEVEL_EN
    output logic [ADDR_W+1:0] LEVEL,
    output logic              ALMOST_FULL,
`endif
    input  logic              RAM_DO
);

    localparam int unsigned      CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth_of(ADDR_W));

    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, addr_q;
    logic              di_q, run_q;
    logic              rd_slot, rd_go, wr_go;
    logic              rd_valid_nxt, rd_data_nxt;

    bram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (wr_go),
        .ptr   (wr_ptr)
    );

    bram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (rd_go),
        .ptr   (rd_ptr)
    );

    // Port arbitration: a starved output register wins the port over a pending write.
    always_comb begin
        rd_slot  = run_q && (state_q == S_IDLE) && (cnt_q != '0) && (!RD_VALID || RD_READY);
        rd_go    = rd_slot && (!RD_VALID || !WR_VALID);
        WR_READY = run_q && (cnt_q != DEPTH_CNT) && !rd_go;
        wr_go    = WR_VALID && WR_READY;

        RAM_EN   = wr_go || rd_go;
        RAM_WE   = wr_go;
        RAM_RST  = 1'b0;
        RAM_ADDR = addr_q;
        RAM_DI   = di_q;
        if (wr_go) begin
            RAM_ADDR = wr_ptr;
            RAM_DI   = WR_DATA;
        end else if (rd_go) begin
            RAM_ADDR = rd_ptr;
        end

        cnt_nxt = cnt_q;
        if (wr_go) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else if (rd_go) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end

        state_nxt = rd_go ? S_RD_WAIT : S_IDLE;

        rd_valid_nxt = RD_VALID;
        rd_data_nxt  = RD_DATA;
        if (state_q == S_RD_WAIT) begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = RAM_DO;
        end else if (RD_VALID && RD_READY) begin
            rd_valid_nxt = 1'b0;
        end
    end

    // run_q keeps the write port closed until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            RD_VALID <= 1'b0;
            RD_DATA  <= 1'b0;
            addr_q   <= '0;
            di_q     <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            RD_VALID <= rd_valid_nxt;
            RD_DATA  <= rd_data_nxt;
            if (RAM_EN) begin
                addr_q <= RAM_ADDR;
            end
            if (wr_go) begin
                di_q <= WR_DATA;
            end
        end
    end

`ifdef BRAM_FIFO_LEVEL_EN
    localparam int unsigned LVL_W = ADDR_W + 2;

    logic [LVL_W-1:0] level_nxt;

    // Level counts RAM contents, the read in flight and the output register.
    always_comb begin
        level_nxt = LVL_W'(cnt_nxt) + LVL_W'(state_nxt == S_RD_WAIT) + LVL_W'(rd_valid_nxt);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LEVEL       <= '0;
            ALMOST_FULL <= 1'b0;
        end else begin
            LEVEL       <= level_nxt;
            ALMOST_FULL <= (level_nxt >= LVL_W'(AFULL_LVL));
        end
    end
`endif

endmodule
